// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Serial frame length in clock cycles, excluding the separating idle cycle.
  function automatic int unsigned frame_cycles(input int unsigned wcnt,
                                               input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
    return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * wcnt;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered occupancy counter.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     w_clk,
  input  logic                     r_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge w_clk) begin
    if (r_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge w_clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: character FIFO feeding a frame serializer with
// configurable data width, parity and stop bits, plus drop and busy status.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WCNT      = 868,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                   w_clk,
  input  logic                   r_rst,
  input  logic                   i_we,
  input  logic [DATA_BITS-1:0]   i_data,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_busy,
  output logic [15:0]            o_drop_cnt,
  output logic                   o_txd
);

  localparam int unsigned TimerW = $clog2(WCNT + 1);
  localparam int unsigned LevelW = $clog2(DEPTH) + 1;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty, pop;
  logic [LevelW-1:0]    fifo_level;

  tx_state_e            state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q;
  logic [15:0]          drop_q;
  logic                 bit_end;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .w_clk (w_clk),
    .r_rst (r_rst),
    .push  (i_we),
    .pop   (pop),
    .wdata (i_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_end = (timer_q == TimerW'(WCNT));

  // State and datapath registers.
  always_ff @(posedge w_clk) begin
    if (r_rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      busy_q    <= (fifo_level != '0) || (state_q != StIdle);
      // Full comes from the registered count, so a same-cycle pop does not save the write.
      if (i_we && fifo_full && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_rdata;
          par_d     = 1'b0;
          timer_d   = TimerW'(1);
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart, StParity: begin
        if (bit_end) begin
          timer_d = TimerW'(1);
          state_d = (state_q == StStart) ? StData : StStop;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = TimerW'(1);
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            timer_d   = '0;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            timer_d   = TimerW'(1);
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line value for the current state; registered into txd_q.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_q[0];
      StParity: txd_d = (PARITY == PAR_ODD) ? ~par_q : par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  assign o_full     = fifo_full;
  assign o_level    = fifo_level;
  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;
  assign o_txd      = txd_q;

endmodule
